count_sequence_checker: RTL and testbench
=========================================

// Module: count_sequence_checker
// PURPOSE
//  Consumer end of the free-running count bus: samples count every clk, acquires lock on a
//  +1 mod 2^WIDTH sequence, then flags and tallies every sequence break. Sits beside the counter
//  in the MyHDL co-sim DUT wrapper and in hardware as a self-check monitor.
// PARAMETERS
//  WIDTH          8   width of count bus
//  LOCK_COUNT     4   consecutive good increments required to declare lock (>=1)
//  ERR_CNT_WIDTH  16  width of saturating error tally
// PORTS
//  clk           in   1              rising-edge clock, shared with count source
//  reset         in   1              asynchronous, active-high reset
//  enable        in   1              1 = checker active; 0 = force IDLE
//  count         in   WIDTH          sampled count bus
//  clear_errors  in   1              synchronous clear of err_count
//  locked        out  1              sequence lock held
//  error         out  1              one-cycle pulse per mismatch while LOCKED
//  err_count     out  ERR_CNT_WIDTH  saturating mismatch tally
//  expected      out  WIDTH          value predicted for next sample
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; locked=0, error=0, err_count=0, expected=0.
//  - All outputs registered; decision on sample taken at edge N is visible after edge N.
//  - FSM (evaluated each rising edge):
//    IDLE:    enable=1 -> ACQUIRE. Else stay.
//    ACQUIRE: expected<=count+1 (mod 2^WIDTH), good<=0 -> TRACK.
//    TRACK:   count==expected: good++, expected<=count+1; good reaches LOCK_COUNT -> LOCKED,
//             locked<=1. Mismatch: good<=0, expected<=count+1, stay TRACK, no error, no tally.
//    LOCKED:  count==expected: expected<=count+1. Mismatch: error<=1 for one cycle,
//             err_count++ (saturating), locked<=0, expected<=count+1, good<=0 -> TRACK.
//  - enable=0 in any state: next edge -> IDLE, locked<=0, error<=0; err_count and expected held.
//  - Wrap: expected after 2^WIDTH-1 is 0; 255->0 (WIDTH=8) is a good increment, never an error.
//  - err_count saturates at 2^ERR_CNT_WIDTH-1; further mismatches still pulse error.
//  - clear_errors=1: err_count<=0; if a mismatch in LOCKED coincides, err_count<=1 (new error
//    counts). clear_errors has no effect on state, locked or expected.
//  - Count-source reset mid-run (count jumps to 0) is an ordinary mismatch: error if LOCKED.
//  - good counter width $clog2(LOCK_COUNT+1); never exceeds LOCK_COUNT.
// CONFIGURATION
//  COUNT_CHECKER_CAPTURE_EN defined: extra outputs bad_value[WIDTH-1:0] and bad_expected
//   [WIDTH-1:0], reset 0, loaded with count and expected on each LOCKED mismatch, else held;
//   cleared by clear_errors (capture wins over clear if same cycle).
//  Undefined: ports and registers absent; all other behaviour identical.
// TESTING (WIDTH=8, LOCK_COUNT=4, ERR_CNT_WIDTH=16)
//  1 reset high, enable=1, count toggling -> locked=0, error=0, err_count=0, expected=0 throughout.
//  2 enable=1, count 10,11,12,...: ACQUIRE on 10, locked=1 after edge sampling 15; error stays 0.
//  3 locked, count ...,253,254,255,0,1 -> no error across wrap; expected=2 after sampling 1.
//  4 locked at 40, inject 99 instead of 41 -> error=1 one cycle, err_count=1, locked=0,
//    expected=100; 100..103 relock after edge sampling 103; with CAPTURE_EN bad_value=99,
//    bad_expected=41.
//  5 err_count forced to 65535 via repeated breaks, one more break -> error pulses, err_count=65535;
//    clear_errors with simultaneous break -> err_count=1.
//  6 locked, enable=0 one cycle -> locked=0 next edge, err_count held; enable=1 -> reacquires,
//    locked after 4 good increments; async reset mid-TRACK -> all outputs 0 immediately.

Source files
------------

// File: rtl/count_sequence_checker.sv
// count_sequence_checker
//   Consumer-side monitor for a free-running count bus. It samples the count
//   every clock and first acquires lock on a +1 (mod 2^WIDTH) sequence. Once
//   locked, it flags every break in the sequence with a one-cycle error pulse
//   and adds the break to a saturating error tally.
//
//   Optional feature macro: COUNT_CHECKER_CAPTURE_EN
//     When defined, the bad_value and bad_expected outputs record the
//     offending sample and the prediction it missed on each break while locked.
//     When undefined, those ports and registers do not exist.
//
//   All outputs are registered. A decision taken on the sample from edge N is
//   visible just after edge N.

module count_sequence_checker #(
  parameter int WIDTH         = 8,
  parameter int LOCK_COUNT    = 4,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [WIDTH-1:0]         count,
  input  logic                     clear_errors,
  output logic                     locked,
  output logic                     error,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [WIDTH-1:0]         expected
`ifdef COUNT_CHECKER_CAPTURE_EN
  ,
  output logic [WIDTH-1:0]         bad_value,
  output logic [WIDTH-1:0]         bad_expected
`endif
);

  // The good counter only needs to reach LOCK_COUNT.
  localparam int GOOD_W = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [GOOD_W-1:0] GOOD_LIM = GOOD_W'(LOCK_COUNT);
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = {ERR_CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_TRACK   = 2'd2,
    S_LOCKED  = 2'd3
  } state_t;

  // Registered state and outputs
  state_t                   r_state;
  logic                     r_locked;
  logic                     r_error;
  logic [ERR_CNT_WIDTH-1:0] r_err_count;
  logic [WIDTH-1:0]         r_expected;
  logic [GOOD_W-1:0]        r_good;

  // Next-state values
  state_t                   w_state_nxt;
  logic                     w_locked_nxt;
  logic                     w_error_nxt;
  logic [ERR_CNT_WIDTH-1:0] w_err_count_nxt;
  logic [WIDTH-1:0]         w_expected_nxt;
  logic [GOOD_W-1:0]        w_good_nxt;

  // Helpers
  logic [WIDTH-1:0]         w_count_inc;
  logic [GOOD_W-1:0]        w_good_inc;
  logic                     w_match;
  logic                     w_break;
  logic                     w_err_sat;

  // Arithmetic shared by the FSM; the count increment wraps naturally.
  always_comb begin
    w_count_inc = count + WIDTH'(1);
    w_good_inc  = r_good + GOOD_W'(1);
    w_match     = (count == r_expected);
    w_err_sat   = (r_err_count == ERR_MAX);
  end

  // Next-state, prediction, lock and error-pulse logic.
  // A low enable overrides every state and suppresses any error decision.
  always_comb begin
    w_state_nxt    = r_state;
    w_locked_nxt   = r_locked;
    w_error_nxt    = 1'b0;
    w_expected_nxt = r_expected;
    w_good_nxt     = r_good;
    w_break        = 1'b0;

    if (!enable) begin
      w_state_nxt  = S_IDLE;
      w_locked_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_ACQUIRE;
        end

        S_ACQUIRE: begin
          w_expected_nxt = w_count_inc;
          w_good_nxt     = '0;
          w_state_nxt    = S_TRACK;
        end

        S_TRACK: begin
          w_expected_nxt = w_count_inc;
          if (w_match) begin
            w_good_nxt = w_good_inc;
            if (w_good_inc >= GOOD_LIM) begin
              w_locked_nxt = 1'b1;
              w_state_nxt  = S_LOCKED;
            end
          end else begin
            // Breaks before lock only restart the run of good increments.
            w_good_nxt = '0;
          end
        end

        S_LOCKED: begin
          w_expected_nxt = w_count_inc;
          if (!w_match) begin
            w_break      = 1'b1;
            w_error_nxt  = 1'b1;
            w_locked_nxt = 1'b0;
            w_good_nxt   = '0;
            w_state_nxt  = S_TRACK;
          end
        end

        default: begin
          w_state_nxt  = S_IDLE;
          w_locked_nxt = 1'b0;
        end
      endcase
    end
  end

  // Error tally: a break on the same cycle as a clear still counts as one.
  always_comb begin
    w_err_count_nxt = r_err_count;
    if (w_break) begin
      if (clear_errors) begin
        w_err_count_nxt = ERR_CNT_WIDTH'(1);
      end else if (!w_err_sat) begin
        w_err_count_nxt = r_err_count + ERR_CNT_WIDTH'(1);
      end
    end else if (clear_errors) begin
      w_err_count_nxt = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_locked    <= 1'b0;
      r_error     <= 1'b0;
      r_err_count <= '0;
      r_expected  <= '0;
      r_good      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_locked    <= w_locked_nxt;
      r_error     <= w_error_nxt;
      r_err_count <= w_err_count_nxt;
      r_expected  <= w_expected_nxt;
      r_good      <= w_good_nxt;
    end
  end

  assign locked    = r_locked;
  assign error     = r_error;
  assign err_count = r_err_count;
  assign expected  = r_expected;

`ifdef COUNT_CHECKER_CAPTURE_EN
  logic [WIDTH-1:0] r_bad_value;
  logic [WIDTH-1:0] r_bad_expected;

  // Capture the offending sample and its prediction; capture beats clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bad_value    <= '0;
      r_bad_expected <= '0;
    end else if (w_break) begin
      r_bad_value    <= count;
      r_bad_expected <= r_expected;
    end else if (clear_errors) begin
      r_bad_value    <= '0;
      r_bad_expected <= '0;
    end
  end

  assign bad_value    = r_bad_value;
  assign bad_expected = r_bad_expected;
`endif

endmodule

// File: tb/tb_count_sequence_checker.sv
// Testbench for count_sequence_checker.
//   u_dut : WIDTH=8, LOCK_COUNT=4, ERR_CNT_WIDTH=16 (main behaviour)
//   u_sat : WIDTH=8, LOCK_COUNT=1, ERR_CNT_WIDTH=4  (tally saturation reachable quickly)
// Inputs change on the falling edge; outputs are sampled on the next falling edge.

module tb_count_sequence_checker;

  localparam int W = 26;  // {locked, error, err_count[15:0], expected[7:0]}

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        enable;
  logic [7:0]  count;
  logic        clear_errors;
  logic        locked;
  logic        error;
  logic [15:0] err_count;
  logic [7:0]  expected;

  logic        s_enable;
  logic [7:0]  s_count;
  logic        s_clear;
  logic        s_locked;
  logic        s_error;
  logic [3:0]  s_err_count;
  logic [7:0]  s_expected;

`ifdef COUNT_CHECKER_CAPTURE_EN
  logic [7:0]  bad_value;
  logic [7:0]  bad_expected;
  logic [7:0]  s_bad_value;
  logic [7:0]  s_bad_expected;
`endif

  count_sequence_checker #(.WIDTH(8), .LOCK_COUNT(4), .ERR_CNT_WIDTH(16)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .count        (count),
    .clear_errors (clear_errors),
    .locked       (locked),
    .error        (error),
    .err_count    (err_count),
    .expected     (expected)
`ifdef COUNT_CHECKER_CAPTURE_EN
    ,
    .bad_value    (bad_value),
    .bad_expected (bad_expected)
`endif
  );

  count_sequence_checker #(.WIDTH(8), .LOCK_COUNT(1), .ERR_CNT_WIDTH(4)) u_sat (
    .clk          (clk),
    .reset        (reset),
    .enable       (s_enable),
    .count        (s_count),
    .clear_errors (s_clear),
    .locked       (s_locked),
    .error        (s_error),
    .err_count    (s_err_count),
    .expected     (s_expected)
`ifdef COUNT_CHECKER_CAPTURE_EN
    ,
    .bad_value    (s_bad_value),
    .bad_expected (s_bad_expected)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks;
  int n_errors;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got locked=%0b error=%0b err_count=%0d expected=%0d, want locked=%0b error=%0b err_count=%0d expected=%0d",
               name, act[25], act[24], act[23:8], act[7:0],
               exp_v[25], exp_v[24], exp_v[23:8], exp_v[7:0]);
    end
  endtask

  task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp_v);
    end
  endtask

  // ---------------- driver ----------------
  // Drive one sample into the selected DUT, push its expected outputs, then
  // pop and compare once the edge has been taken.
  task automatic step(input int sel, input logic en, input logic [7:0] cnt, input logic clr,
                      input logic el, input logic ee, input logic [15:0] ec,
                      input logic [7:0] ex, input string name);
    logic [W-1:0] act;
    logic [W-1:0] exp_v;
    if (sel == 0) begin
      enable = en; count = cnt; clear_errors = clr;
    end else begin
      s_enable = en; s_count = cnt; s_clear = clr;
    end
    exp_q.push_back({el, ee, ec, ex});
    @(posedge clk);
    @(negedge clk);
    if (sel == 0) act = {locked, error, err_count, expected};
    else          act = {s_locked, s_error, 12'd0, s_err_count, s_expected};
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard queue empty", name);
    end else begin
      exp_v = exp_q.pop_front();
      check(name, act, exp_v);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        en;
    logic [7:0]  cnt;
    logic        clr;
    logic        el;
    logic        ee;
    logic [15:0] ec;
    logic [7:0]  ex;
  } vec_t;

  vec_t vecs[13];

  logic [7:0]  v_cnt;
  logic [7:0]  cur;
  logic [7:0]  b;
  logic [15:0] ec;

  initial begin
    // acquire from IDLE with 10,11,...; lock after the sample of 15
    vecs[0]  = '{1'b1, 8'd10,  1'b0, 1'b0, 1'b0, 16'd0, 8'd0};
    vecs[1]  = '{1'b1, 8'd11,  1'b0, 1'b0, 1'b0, 16'd0, 8'd12};
    vecs[2]  = '{1'b1, 8'd12,  1'b0, 1'b0, 1'b0, 16'd0, 8'd13};
    vecs[3]  = '{1'b1, 8'd13,  1'b0, 1'b0, 1'b0, 16'd0, 8'd14};
    vecs[4]  = '{1'b1, 8'd14,  1'b0, 1'b0, 1'b0, 16'd0, 8'd15};
    vecs[5]  = '{1'b1, 8'd15,  1'b0, 1'b1, 1'b0, 16'd0, 8'd16};
    vecs[6]  = '{1'b1, 8'd16,  1'b0, 1'b1, 1'b0, 16'd0, 8'd17};
    // locked at 40, 99 injected instead of 41, relock on 100..103
    vecs[7]  = '{1'b1, 8'd99,  1'b0, 1'b0, 1'b1, 16'd1, 8'd100};
    vecs[8]  = '{1'b1, 8'd100, 1'b0, 1'b0, 1'b0, 16'd1, 8'd101};
    vecs[9]  = '{1'b1, 8'd101, 1'b0, 1'b0, 1'b0, 16'd1, 8'd102};
    vecs[10] = '{1'b1, 8'd102, 1'b0, 1'b0, 1'b0, 16'd1, 8'd103};
    vecs[11] = '{1'b1, 8'd103, 1'b0, 1'b1, 1'b0, 16'd1, 8'd104};
    vecs[12] = '{1'b1, 8'd104, 1'b0, 1'b1, 1'b0, 16'd1, 8'd105};

    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    enable = 1'b1; count = 8'd0; clear_errors = 1'b0;
    s_enable = 1'b0; s_count = 8'd0; s_clear = 1'b0;
    @(negedge clk);

    // reset held with enable=1 and a moving count: everything stays 0
    for (int i = 0; i < 4; i++)
      step(0, 1'b1, 8'(i * 37 + 3), 1'b0, 1'b0, 1'b0, 16'd0, 8'd0, "reset_hold");
    reset = 1'b0;

    for (int i = 0; i < 7; i++)
      step(0, vecs[i].en, vecs[i].cnt, vecs[i].clr, vecs[i].el, vecs[i].ee,
           vecs[i].ec, vecs[i].ex, $sformatf("vec%0d", i));

    // run through the wrap 255 -> 0 and on up to 40 while locked
    for (int c = 17; c <= 256 + 40; c++) begin
      v_cnt = 8'(c);
      step(0, 1'b1, v_cnt, 1'b0, 1'b1, 1'b0, 16'd0, v_cnt + 8'd1,
           (c >= 255 && c <= 257) ? "wrap" : "locked_run");
    end

    for (int i = 7; i < 13; i++) begin
      step(0, vecs[i].en, vecs[i].cnt, vecs[i].clr, vecs[i].el, vecs[i].ee,
           vecs[i].ec, vecs[i].ex, $sformatf("vec%0d", i));
`ifdef COUNT_CHECKER_CAPTURE_EN
      check_val("bad_value_99", bad_value, 8'd99);
      check_val("bad_expected_41", bad_expected, 8'd41);
`endif
    end

    // clear while locked, clear with a coincident break, clear alone
    step(0, 1'b1, 8'd105, 1'b1, 1'b1, 1'b0, 16'd0, 8'd106, "clear_locked");
    step(0, 1'b1, 8'd7,   1'b1, 1'b0, 1'b1, 16'd1, 8'd8,   "clear_with_break");
`ifdef COUNT_CHECKER_CAPTURE_EN
    check_val("capture_over_clear_val", bad_value, 8'd7);
    check_val("capture_over_clear_exp", bad_expected, 8'd106);
`endif
    step(0, 1'b1, 8'd8,   1'b1, 1'b0, 1'b0, 16'd0, 8'd9,   "clear_only");
`ifdef COUNT_CHECKER_CAPTURE_EN
    check_val("capture_cleared_val", bad_value, 8'd0);
    check_val("capture_cleared_exp", bad_expected, 8'd0);
`endif
    step(0, 1'b1, 8'd9,  1'b0, 1'b0, 1'b0, 16'd0, 8'd10, "track");
    step(0, 1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 16'd0, 8'd11, "track");
    step(0, 1'b1, 8'd11, 1'b0, 1'b1, 1'b0, 16'd0, 8'd12, "relock");
    step(0, 1'b1, 8'd50, 1'b0, 1'b0, 1'b1, 16'd1, 8'd51, "break");
    step(0, 1'b1, 8'd51, 1'b0, 1'b0, 1'b0, 16'd1, 8'd52, "track");
    step(0, 1'b1, 8'd52, 1'b0, 1'b0, 1'b0, 16'd1, 8'd53, "track");
    step(0, 1'b1, 8'd53, 1'b0, 1'b0, 1'b0, 16'd1, 8'd54, "track");
    step(0, 1'b1, 8'd54, 1'b0, 1'b1, 1'b0, 16'd1, 8'd55, "relock");

    // enable low: unlock, no error for a bad sample, tally and prediction held
    step(0, 1'b0, 8'd200, 1'b0, 1'b0, 1'b0, 16'd1, 8'd55, "disable");
    step(0, 1'b0, 8'd56,  1'b0, 1'b0, 1'b0, 16'd1, 8'd55, "idle_hold");
    step(0, 1'b1, 8'd57,  1'b0, 1'b0, 1'b0, 16'd1, 8'd55, "reenable");
    step(0, 1'b1, 8'd58,  1'b0, 1'b0, 1'b0, 16'd1, 8'd59, "reacquire");
    step(0, 1'b1, 8'd59,  1'b0, 1'b0, 1'b0, 16'd1, 8'd60, "track");
    step(0, 1'b1, 8'd60,  1'b0, 1'b0, 1'b0, 16'd1, 8'd61, "track");
    step(0, 1'b1, 8'd61,  1'b0, 1'b0, 1'b0, 16'd1, 8'd62, "track");
    step(0, 1'b1, 8'd62,  1'b0, 1'b1, 1'b0, 16'd1, 8'd63, "relock_4");

    // count source resets to 0: ordinary break while locked
    step(0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 16'd2, 8'd1, "src_reset");
    step(0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 16'd2, 8'd2, "track");

    // asynchronous reset in the middle of TRACK, away from any clock edge
    #2 reset = 1'b1;
    #1 check("async_reset", {locked, error, err_count, expected}, '0);
`ifdef COUNT_CHECKER_CAPTURE_EN
    check_val("async_reset_bad_value", bad_value, 8'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    step(0, 1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0, "post_reset");
    enable = 1'b0;

    // saturation on the narrow-tally instance (LOCK_COUNT=1)
    step(1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0, "sat_acquire");
    step(1, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 16'd0, 8'd2, "sat_track");
    step(1, 1'b1, 8'd2, 1'b0, 1'b1, 1'b0, 16'd0, 8'd3, "sat_lock");
    cur = 8'd2;
    ec  = 16'd0;
    for (int k = 0; k < 20; k++) begin
      b  = cur + 8'd50;
      ec = (ec == 16'd15) ? 16'd15 : ec + 16'd1;
      step(1, 1'b1, b,        1'b0, 1'b0, 1'b1, ec, b + 8'd1, (k >= 15) ? "sat_hold" : "sat_break");
      step(1, 1'b1, b + 8'd1, 1'b0, 1'b1, 1'b0, ec, b + 8'd2, "sat_relock");
      cur = b + 8'd1;
    end
    b = cur + 8'd50;
    step(1, 1'b1, b, 1'b1, 1'b0, 1'b1, 16'd1, b + 8'd1, "sat_clear_with_break");

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
